sccb_config_sequencer: RTL

- Sequences OV7670 register configuration through SCCB_master's 3-phase-write request interface.
- Walks a fixed register table of {addr, data} pairs and issues one write per entry.
- Waits for each completion, then enforces an inter-write gap, plus a longer settle delay after the COM7 soft reset.
- Provides timeout/retry handling and busy/done/error status for LEDs/HEX. Replaces the unused WRITE_COM7/WRITE_COM15/CONTINUE stub in the top level.

---
 rtl/sccb_cfg_pkg.sv | 23 ++
 rtl/sccb_reg_rom.sv | 20 ++
 rtl/sccb_config_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sccb_cfg_pkg.sv
// Shared types and OV7670 register constants for the SCCB configuration sequencer.
package sccb_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      REQ,
      WAIT_ACK,
      GAP,
      DONE,
      ERROR
   } state_t;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } sccb_reg_t;

   localparam logic [7:0] COM7  = 8'h12;
   localparam logic [7:0] COM15 = 8'h40;
   localparam logic [7:0] CLKRC = 8'h11;

endpackage

// File: rtl/sccb_reg_rom.sv
// OV7670 register table: index to {addr, data}; unused indices read as zero.
module sccb_reg_rom
   import sccb_cfg_pkg::*;
(
   input  logic [5:0] index,
   output sccb_reg_t  entry
);

   always_comb begin
      entry = '0;
      case (index)
         6'd0:    entry = '{addr: COM7,  data: 8'h80};
         6'd1:    entry = '{addr: COM7,  data: 8'h04};
         6'd2:    entry = '{addr: COM15, data: 8'hD0};
         6'd3:    entry = '{addr: CLKRC, data: 8'h01};
         default: entry = '0;
      endcase
   end

endmodule

// File: rtl/sccb_config_sequencer.sv
// Walks the register ROM and issues one SCCB 3-phase write per entry,
// with gaps, a post-soft-reset settle delay, timeout and retry.
module sccb_config_sequencer
   import sccb_cfg_pkg::*;
#(
   parameter int NUM_REGS          = 4,
   parameter int GAP_CYCLES        = 256,
   parameter int RESET_WAIT_CYCLES = 50000,
   parameter int TIMEOUT_CYCLES    = 200000,
   parameter int MAX_RETRY         = 3
)
(
   input  logic       Clk,
   input  logic       Reset,
   input  logic       start,
   input  logic       sccb_complete,
   output logic       sccb_write3_rq,
   output logic [7:0] sccb_addr,
   output logic [7:0] sccb_data,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [5:0] reg_index,
   output logic [1:0] retry_count
);

   localparam int MAX_A = (GAP_CYCLES > RESET_WAIT_CYCLES) ?
                          GAP_CYCLES : RESET_WAIT_CYCLES;
   localparam int MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ?
                            MAX_A : TIMEOUT_CYCLES;
   localparam int CW = $clog2(MAX_CYC + 1);

   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t GAP_LD = cnt_t'(GAP_CYCLES - 1);
   localparam cnt_t RST_LD = cnt_t'(RESET_WAIT_CYCLES - 1);
   localparam cnt_t TMO_LAST = cnt_t'(TIMEOUT_CYCLES - 1);
   localparam logic [5:0] LAST_IDX = 6'(NUM_REGS - 1);

   state_t    state;
   logic [2:0] st_sync;
   logic [2:0] cp_sync;
   logic      start_rise;
   logic      cp_rise;
   logic      gap_retry;
   cnt_t      gap_cnt;
   cnt_t      tmo_cnt;
   sccb_reg_t rom_q;

   sccb_reg_rom u_rom (
      .index (reg_index),
      .entry (rom_q)
   );

   // Both inputs are asynchronous: two flops to settle, a third for the edge.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         st_sync    <= '0;
         cp_sync    <= '0;
         start_rise <= 1'b0;
      end else begin
         st_sync    <= {st_sync[1:0], start};
         cp_sync    <= {cp_sync[1:0], sccb_complete};
         start_rise <= st_sync[1] & ~st_sync[2];
      end
   end

   assign cp_rise = cp_sync[1] & ~cp_sync[2];

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state          <= IDLE;
         sccb_write3_rq <= 1'b0;
         sccb_addr      <= '0;
         sccb_data      <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         error          <= 1'b0;
         reg_index      <= '0;
         retry_count    <= '0;
         gap_retry      <= 1'b0;
         gap_cnt        <= '0;
         tmo_cnt        <= '0;
      end else begin
         unique case (state)
            IDLE, DONE, ERROR: begin
               if (start_rise) begin
                  done        <= 1'b0;
                  error       <= 1'b0;
                  reg_index   <= '0;
                  retry_count <= '0;
                  gap_retry   <= 1'b0;
                  busy        <= 1'b1;
                  state       <= LOAD;
               end
            end
            LOAD: begin
               sccb_addr      <= rom_q.addr;
               sccb_data      <= rom_q.data;
               busy           <= 1'b1;
               sccb_write3_rq <= 1'b1;
               state          <= REQ;
            end
            REQ: begin
               tmo_cnt <= '0;
               state   <= WAIT_ACK;
            end
            WAIT_ACK: begin
               // A completion in the timeout cycle still counts as success.
               if (cp_rise) begin
                  sccb_write3_rq <= 1'b0;
                  gap_retry      <= 1'b0;
                  gap_cnt        <= (reg_index == 6'd0) ? RST_LD : GAP_LD;
                  state          <= GAP;
               end else if (tmo_cnt == TMO_LAST) begin
                  sccb_write3_rq <= 1'b0;
                  if (int'(retry_count) < MAX_RETRY) begin
                     retry_count <= retry_count + 2'd1;
                     gap_retry   <= 1'b1;
                     gap_cnt     <= GAP_LD;
                     state       <= GAP;
                  end else begin
                     busy  <= 1'b0;
                     error <= 1'b1;
                     state <= ERROR;
                  end
               end else if (tmo_cnt != '1) begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            GAP: begin
               if (gap_cnt != '0) begin
                  gap_cnt <= gap_cnt - 1'b1;
               end else if (gap_retry) begin
                  gap_retry <= 1'b0;
                  state     <= LOAD;
               end else if (reg_index == LAST_IDX) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  reg_index   <= reg_index + 6'd1;
                  retry_count <= '0;
                  state       <= LOAD;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
